// File: rtl/sprite_plotter.sv
// Erases a 4x4 sprite at its last drawn position and redraws it at a newly
// sampled one, emitting one pixel per clock for a 160x120 frame buffer.
module sprite_plotter #(
    parameter logic [15:0] SPR_MASK     = 16'hFFFF,
    parameter logic [2:0]  SPR_COLOUR   = 3'b001,
    parameter logic [2:0]  ERASE_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] pos_x,
    input  logic [6:0] pos_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  cur_x_q, cur_x_d;
    logic [6:0]  cur_y_q, cur_y_d;
    logic [7:0]  old_x_q, old_x_d;
    logic [6:0]  old_y_q, old_y_d;
    logic        old_valid_q, old_valid_d;

    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [8:0]  sum_x;
    logic [8:0]  sum_y;
    logic        clipped;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            cur_x_q     <= 8'd0;
            cur_y_q     <= 7'd0;
            old_x_q     <= 8'd0;
            old_y_q     <= 7'd0;
            old_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            old_valid_q <= old_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        old_valid_d = old_valid_q;

        case (state_q)
            S_IDLE: begin
                // Ticks are only honoured here; busy states drop them silently.
                if (frame_tick) begin
                    cur_x_d = pos_x;
                    cur_y_d = pos_y;
                    cnt_d   = 4'd0;
                    state_d = old_valid_q ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d   = 4'd0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d       = 4'd0;
                    old_x_d     = cur_x_q;
                    old_y_d     = cur_y_q;
                    old_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel address: row-major scan of the 4x4 box, one extra bit to detect overflow.
    always_comb begin
        base_x  = (state_q == S_ERASE) ? old_x_q : cur_x_q;
        base_y  = (state_q == S_ERASE) ? old_y_q : cur_y_q;
        sum_x   = {1'b0, base_x} + {7'd0, cnt_q[1:0]};
        sum_y   = {2'b0, base_y} + {7'd0, cnt_q[3:2]};
        clipped = (sum_x >= 9'd160) || (sum_y >= 9'd120);
    end

    always_comb begin
        x      = 8'd0;
        y      = 7'd0;
        colour = ERASE_COLOUR;
        plot   = 1'b0;
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);

        case (state_q)
            S_ERASE: begin
                x      = sum_x[7:0];
                y      = sum_y[6:0];
                colour = ERASE_COLOUR;
                plot   = ~clipped;
            end
            S_DRAW: begin
                x      = sum_x[7:0];
                y      = sum_y[6:0];
                colour = SPR_COLOUR;
                plot   = SPR_MASK[cnt_q] & ~clipped;
            end
            default: begin
            end
        endcase
    end

endmodule
